// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, one-cycle strobes per frame.
// Optional parity bit between data and stop bits when UART_RX_PARITY_EN is defined.
module uart_rx_byte #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 4) begin : g_cpb_check
    $error("uart_rx_byte: CLKS_PER_BIT (%0d) must be >= 4", CLKS_PER_BIT);
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_parity_check
    $error("uart_rx_byte: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t state;
  state_t state_next;

  logic          rx_meta;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  logic shift_en;
  logic stop_ok;
  logic stop_bad;
  logic bit_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (!rx_s) state_next = START;
      START:     if (cnt == HALF_M1) state_next = rx_s ? IDLE : DATA;
      DATA: begin
        if (cnt == FULL_M1 && bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY:    if (cnt == FULL_M1) state_next = STOP;
`endif
      // Leave STOP at mid stop bit so a start bit right after it is not missed.
      STOP:      if (cnt == FULL_M1) state_next = rx_s ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rx_s) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    bit_end  = (cnt == FULL_M1);
    shift_en = (state == DATA) && bit_end;
    stop_ok  = (state == STOP) && bit_end && rx_s;
    stop_bad = (state == STOP) && bit_end && !rx_s;
  end

  always_ff @(posedge clk) begin
    if (rst || state == IDLE || state_next != state || shift_en) cnt <= '0;
    else                                                         cnt <= cnt + 1'b1;
  end

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  logic par_bad;
  logic parity_err_q;

  always_ff @(posedge clk) begin
    if (rst || state == START) par_bad <= 1'b0;
    else if (state == PARITY && bit_end) par_bad <= (rx_s != ((^shreg) ^ PAR_ODD));
  end

  always_ff @(posedge clk) begin
    if (rst) parity_err_q <= 1'b0;
    else     parity_err_q <= stop_ok && par_bad;
  end
  assign parity_err = parity_err_q;
`else
  logic par_bad;
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx    <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= stop_bad;
      if (state == START) bit_idx <= '0;
      if (shift_en) begin
        shreg[bit_idx] <= rx_s;
        bit_idx        <= bit_idx + 1'b1;
      end
      if (stop_ok && !par_bad) begin
        data_out   <= shreg;
        data_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 16 clocks per bit, with a byte-to-word assembler model.
module tb_uart_rx_byte;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int nvalid = 0;
  int nferr = 0;
  int nperr = 0;
  int overlap = 0;
  int busy_cyc = 0;
  logic [63:0] word = '0;

  int v0, f0, p0, b0;

`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BUSY = 168;
`else
  localparam int FRAME_BUSY = 152;
`endif

  uart_rx_byte #(.CLK_FREQ(16), .BAUD_RATE(1), .PARITY_ODD(0)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data_out(data_out), .data_valid(data_valid),
    .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid) begin
        nvalid = nvalid + 1;
        word = {word[55:0], data_out};
      end
      if (frame_err) nferr = nferr + 1;
      if (parity_err) nperr = nperr + 1;
      if ((32'(data_valid) + 32'(frame_err) + 32'(parity_err)) > 1) overlap = overlap + 1;
      if (busy) busy_cyc = busy_cyc + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    hold(1'b0, 16);
    for (int i = 0; i < 8; i++) hold(b[i], 16);
`ifdef UART_RX_PARITY_EN
    hold(par, 16);
`else
    if (par !== par) hold(1'b1, 0);
`endif
    hold(stop, 16);
  endtask

  task automatic snap();
    v0 = nvalid; f0 = nferr; p0 = nperr; b0 = busy_cyc;
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data_out", 64'(data_out), 64'h0);
    check("rst_data_valid", 64'(data_valid), 64'h0);
    check("rst_frame_err", 64'(frame_err), 64'h0);
    check("rst_parity_err", 64'(parity_err), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    rst = 1'b0;
    hold(1'b1, 10);

    // single frame 0xA5 (four ones -> even parity bit 0)
    snap();
    send_frame(8'hA5, 1'b0, 1'b1);
    hold(1'b1, 20);
    check("a5_valid_cnt", 64'(nvalid - v0), 64'd1);
    check("a5_data_out", 64'(data_out), 64'hA5);
    check("a5_frame_err", 64'(nferr - f0), 64'd0);
    check("a5_busy_cycles", 64'(busy_cyc - b0), 64'(FRAME_BUSY));
    check("a5_busy_idle", 64'(busy), 64'h0);

    // eight back-to-back frames into the word assembler
    snap();
    word = '0;
    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'h02, 1'b1, 1'b1);
    send_frame(8'h03, 1'b0, 1'b1);
    send_frame(8'h04, 1'b1, 1'b1);
    send_frame(8'h05, 1'b0, 1'b1);
    send_frame(8'h06, 1'b0, 1'b1);
    send_frame(8'h07, 1'b1, 1'b1);
    send_frame(8'h08, 1'b1, 1'b1);
    hold(1'b1, 20);
    check("b2b_valid_cnt", 64'(nvalid - v0), 64'd8);
    check("b2b_word", word, 64'h0102030405060708);
    check("b2b_frame_err", 64'(nferr - f0), 64'd0);

    // start-bit glitch: 4 low cycles
    snap();
    hold(1'b0, 4);
    hold(1'b1, 30);
    check("glitch_busy_cycles", 64'(busy_cyc - b0), 64'd8);
    check("glitch_valid_cnt", 64'(nvalid - v0), 64'd0);
    check("glitch_frame_err", 64'(nferr - f0), 64'd0);
    check("glitch_busy_idle", 64'(busy), 64'h0);
    send_frame(8'h3C, 1'b0, 1'b1);
    hold(1'b1, 20);
    check("glitch_next_valid", 64'(nvalid - v0), 64'd1);
    check("glitch_next_data", 64'(data_out), 64'h3C);

    // bad stop bit followed by a held-low break
    snap();
    send_frame(8'h77, 1'b0, 1'b0);
    hold(1'b0, 40);
    hold(1'b1, 20);
    check("break_frame_err_cnt", 64'(nferr - f0), 64'd1);
    check("break_valid_cnt", 64'(nvalid - v0), 64'd0);
    check("break_data_hold", 64'(data_out), 64'h3C);
    check("break_busy_idle", 64'(busy), 64'h0);
    send_frame(8'h3C, 1'b0, 1'b1);
    hold(1'b1, 20);
    check("break_next_valid", 64'(nvalid - v0), 64'd1);
    check("break_next_data", 64'(data_out), 64'h3C);
    check("break_next_ferr", 64'(nferr - f0), 64'd1);

    // reset in the middle of data bit 4 of 0xFF
    snap();
    hold(1'b0, 16);
    hold(1'b1, 72);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_data_out", 64'(data_out), 64'h0);
    check("midrst_valid", 64'(data_valid), 64'h0);
    check("midrst_ferr", 64'(frame_err), 64'h0);
    check("midrst_perr", 64'(parity_err), 64'h0);
    check("midrst_busy", 64'(busy), 64'h0);
    rst = 1'b0;
    hold(1'b1, 72);
    check("midrst_no_strobe", 64'(nvalid - v0), 64'd0);
    check("midrst_data_kept0", 64'(data_out), 64'h0);
    send_frame(8'h5A, 1'b0, 1'b1);
    hold(1'b1, 20);
    check("midrst_next_valid", 64'(nvalid - v0), 64'd1);
    check("midrst_next_data", 64'(data_out), 64'h5A);

`ifdef UART_RX_PARITY_EN
    snap();
    send_frame(8'h03, 1'b1, 1'b1);
    hold(1'b1, 20);
    check("par_bad_perr", 64'(nperr - p0), 64'd1);
    check("par_bad_valid", 64'(nvalid - v0), 64'd0);
    check("par_bad_data_hold", 64'(data_out), 64'h5A);
    send_frame(8'h03, 1'b0, 1'b1);
    hold(1'b1, 20);
    check("par_ok_valid", 64'(nvalid - v0), 64'd1);
    check("par_ok_data", 64'(data_out), 64'h03);
    check("par_ok_perr", 64'(nperr - p0), 64'd1);
`else
    check("parity_err_never", 64'(nperr), 64'd0);
`endif

    check("strobe_overlap", 64'(overlap), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- UART receiver front end: oversamples asynchronous serial line rx, recovers 8N1 frames (LSB first), emits one byte plus a one-cycle strobe per good frame.
- Sits directly upstream of the byte-to-word assembler: data_out drives its serial_in, data_valid drives its load.
- Eight consecutive good frames therefore produce one 64-bit word downstream.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD_RATE, 115200: line bit rate.
- PARITY_ODD, 0: parity sense, 1 = odd, 0 = even. Only used with UART_RX_PARITY_EN.
- CLKS_PER_BIT (localparam): CLK_FREQ/BAUD_RATE, integer truncation. Must be >= 4; elaborate-time $error otherwise.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- rx  input  1  asynchronous serial line, idle high
- data_out  output  8  last good received byte
- data_valid  output  1  one-cycle strobe, data_out newly updated
- frame_err  output  1  one-cycle strobe, stop bit sampled low
- parity_err  output  1  one-cycle strobe, parity mismatch (tied 0 without macro)
- busy  output  1  high whenever FSM not in IDLE

Behaviour:
- Reset values:
  - data_out=0, data_valid=0, frame_err=0, parity_err=0, busy=0.
  - FSM=IDLE; bit counter and shift register cleared.
  - Both synchronizer flops =1.
- Synchronizer: rx passes through two flops (rx_s). The FSM sees rx_s only, 2 cycles after rx.
- Baud counter: width $clog2(CLKS_PER_BIT). Cleared on every state entry. Sample strobe when the counter reaches its target.
- IDLE: on rx_s==0, go to START.
- START: at count CLKS_PER_BIT/2-1 (mid start bit), sample rx_s:
  - 0: go to DATA, bit_idx=0.
  - 1: glitch; go to IDLE, no strobe.
- DATA:
  - Every CLKS_PER_BIT cycles, shift rx_s in at bit[bit_idx] (LSB first).
  - After bit 7, go to STOP (or PARITY with the macro).
- STOP: after CLKS_PER_BIT cycles, sample rx_s:
  - 1: data_out<=shift register. data_valid=1 on the next cycle only. Go to IDLE immediately at mid stop bit, so back-to-back frames are accepted.
  - 0: frame_err=1 for one cycle. data_out unchanged, no data_valid. Go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s==1, then go to IDLE. A held-low break line yields exactly one frame_err, not a stream of spurious frames.
- data_out holds its value between frames (not cleared after the strobe).
- data_valid, frame_err and parity_err are never asserted in the same cycle.
- rst mid-frame overrides everything: return to reset values the next cycle, no strobe. The partial byte is discarded.
- rx changes while in STOP/DATA between sample points are ignored. Only mid-bit samples count.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP; one bit time, sampled mid-bit.
  - Expected bit = XOR of the data bits, inverted when PARITY_ODD=1.
  - On mismatch, the frame completes through STOP, then parity_err pulses in the strobe cycle. data_valid is suppressed, data_out is unchanged.
  - If the stop bit is also bad, frame_err takes priority and parity_err is not pulsed.
- Undefined:
  - No PARITY state; 10-bit frames.
  - parity_err is constant 0.
  - PARITY_ODD is ignored.

Test Plan (CLK_FREQ=16, BAUD_RATE=1, i.e. CLKS_PER_BIT=16):
- Single frame 0xA5, ideal timing -> data_out=0xA5, one data_valid pulse, busy high for the frame only, frame_err=0.
- Eight back-to-back frames 0x01..0x08, no idle gap, fed into the word assembler -> 8 data_valid pulses in order; assembler outputs 64'h0102030405060708.
- rx low for 4 cycles then high -> busy pulses, no data_valid or frame_err, FSM back in IDLE. A following frame 0x3C is received correctly.
- Frame 0x77 with stop bit low, line held low 40 cycles, then high, then frame 0x3C:
  - Exactly one frame_err pulse.
  - data_out stays at its prior value until 0x3C is received with data_valid.
- rst asserted for 1 cycle during data bit 4 of frame 0xFF, then full frame 0x5A -> all outputs 0 after reset, no strobe for the aborted frame, then data_out=0x5A with data_valid.
- With UART_RX_PARITY_EN, PARITY_ODD=0:
  - Frame 0x03 with parity bit 1 -> parity_err pulse, no data_valid.
  - Frame 0x03 with parity bit 0 -> data_valid, data_out=0x03.
